regfile_mp: RTL and testbench

Parametrised multi-read-port register file for the pipelined datapath. It generalises the 2-read/1-write 32x32 register file with:
- configurable width, depth and read-port count
- byte-enable writes
- optional same-cycle write-to-read bypass
- hardwired zero register
- per-register pending-write scoreboard, so the hazard unit can stall consumers of in-flight results

---
 rtl/regfile_mp_if.sv | 27 ++
 rtl/regfile_mp.sv | 85 ++++++++
 tb/tb_regfile_mp.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Register-file access bundle: NRD combinational read ports, one byte-enabled write port, one issue port.
// The master drives addresses, writes and issues; the slave returns read data and busy flags.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
);
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [DATA_W/8-1:0]   wr_be;
  logic                  iss_en;
  logic [ADDR_W-1:0]     iss_addr;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, wr_be, iss_en, iss_addr,
    input  rd_data, rd_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, wr_be, iss_en, iss_addr,
    output rd_data, rd_busy
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with byte-enable writes, optional write bypass and pending-write scoreboard.
// Reads and busy flags are combinational (zero latency); writes and issues take effect at the clock edge.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  regfile_mp_if.slave io_rf
);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NBYTES = DATA_W / 8;

  logic [DATA_W-1:0] r_rf [DEPTH];
  logic [DEPTH-1:0]  r_busy;

  logic [DATA_W-1:0] w_mask;
  logic [DATA_W-1:0] w_merged;
  logic              w_wr_zero;
  logic [DEPTH-1:0]  w_busy_nxt;
  logic [ADDR_W-1:0] w_ra  [NRD];
  logic              w_hit [NRD];

  always_comb begin
    w_mask = '0;
    for (int k = 0; k < NBYTES; k++) begin
      w_mask[8*k +: 8] = {8{io_rf.wr_be[k]}};
    end
  end

  // Same value feeds both the storage update and the bypass path.
  assign w_merged  = (io_rf.wr_data & w_mask) | (r_rf[io_rf.wr_addr] & ~w_mask);
  assign w_wr_zero = (ZERO_REG != 0) && (io_rf.wr_addr == '0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int j = 0; j < DEPTH; j++) begin
        r_rf[j] <= '0;
      end
    end else if (io_rf.wr_en && !w_wr_zero) begin
      r_rf[io_rf.wr_addr] <= w_merged;
    end
  end

  // Issue is applied after completion so a new producer supersedes the one retiring.
  always_comb begin
    w_busy_nxt = r_busy;
    if (io_rf.wr_en) begin
      w_busy_nxt[io_rf.wr_addr] = 1'b0;
    end
    if (io_rf.iss_en) begin
      w_busy_nxt[io_rf.iss_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      w_busy_nxt[0] = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  always_comb begin
    io_rf.rd_data = '0;
    io_rf.rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      w_ra[i]  = io_rf.rd_addr[i*ADDR_W +: ADDR_W];
      w_hit[i] = (BYPASS != 0) && i_rst_n && io_rf.wr_en && (io_rf.wr_addr == w_ra[i]);
      if ((ZERO_REG != 0) && (w_ra[i] == '0)) begin
        io_rf.rd_data[i*DATA_W +: DATA_W] = '0;
        io_rf.rd_busy[i]                  = 1'b0;
      end else begin
        io_rf.rd_data[i*DATA_W +: DATA_W] = w_hit[i] ? w_merged : r_rf[w_ra[i]];
        io_rf.rd_busy[i]                  = r_busy[w_ra[i]] && !w_hit[i];
      end
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a 4-port bypassing instance and a 2-port non-bypassing instance share all stimulus.
// Each vector carries hand-derived pre-edge outputs for both instances.
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;

  localparam logic [31:0] A1 = 32'hA1A1A1A1;
  localparam logic [31:0] B2 = 32'hB2B2B2B2;
  localparam logic [31:0] C3 = 32'hC3C3C3C3;
  localparam logic [31:0] F1 = 32'hF1F1F1F1;
  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] M5 = 32'h11BB33DD;
  localparam logic [31:0] P5 = 32'h11223344;
  localparam logic [31:0] Z  = 32'h0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(4)) bus_a ();
  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(2)) bus_b ();

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(4), .BYPASS(1), .ZERO_REG(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .io_rf(bus_a)
  );
  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(2), .BYPASS(0), .ZERO_REG(1)) dut_nb (
    .i_clk(clk), .i_rst_n(rst_n), .io_rf(bus_b)
  );

  assign bus_b.rd_addr  = bus_a.rd_addr[2*AW-1:0];
  assign bus_b.wr_en    = bus_a.wr_en;
  assign bus_b.wr_addr  = bus_a.wr_addr;
  assign bus_b.wr_data  = bus_a.wr_data;
  assign bus_b.wr_be    = bus_a.wr_be;
  assign bus_b.iss_en   = bus_a.iss_en;
  assign bus_b.iss_addr = bus_a.iss_addr;

  typedef struct packed {
    logic             rs;
    logic             we;
    logic [4:0]       wa;
    logic [31:0]      wd;
    logic [3:0]       be;
    logic             ie;
    logic [4:0]       ia;
    logic [3:0][4:0]  ra;
    logic [3:0][31:0] ed;
    logic [3:0]       eb;
    logic [1:0][31:0] nd;
    logic [1:0]       nb;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(logic rs, logic we, logic [4:0] wa, logic [31:0] wd, logic [3:0] be,
                              logic ie, logic [4:0] ia, logic [19:0] ra, logic [127:0] ed,
                              logic [3:0] eb, logic [63:0] nd, logic [1:0] nb);
    vec_t v;
    v.rs = rs; v.we = we; v.wa = wa; v.wd = wd; v.be = be; v.ie = ie; v.ia = ia;
    v.ra = ra; v.ed = ed; v.eb = eb; v.nd = nd; v.nb = nb;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive at the falling edge, queue the expectation, compare before the next rising edge.
  task automatic run_vec(vec_t v, string tag);
    vec_t e;
    @(negedge clk);
    rst_n          = v.rs;
    bus_a.wr_en    = v.we;
    bus_a.wr_addr  = v.wa;
    bus_a.wr_data  = v.wd;
    bus_a.wr_be    = v.be;
    bus_a.iss_en   = v.ie;
    bus_a.iss_addr = v.ia;
    bus_a.rd_addr  = v.ra;
    exp_q.push_back(v);
    #2;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("%s a.data%0d", tag, i), bus_a.rd_data[i*DW +: DW], e.ed[i]);
        chk($sformatf("%s a.busy%0d", tag, i), {31'b0, bus_a.rd_busy[i]}, {31'b0, e.eb[i]});
      end
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("%s b.data%0d", tag, i), bus_b.rd_data[i*DW +: DW], e.nd[i]);
        chk($sformatf("%s b.busy%0d", tag, i), {31'b0, bus_b.rd_busy[i]}, {31'b0, e.nb[i]});
      end
    end
  endtask

  initial begin
    logic [31:0] prev;
    logic [31:0] cur;
    logic [7:0]  byt;

    //            rs we wa     wd             be     ie ia     ra {p3,p2,p1,p0}               ed {p3,p2,p1,p0}              eb       nd {p1,p0}   nb
    tbl.push_back(mk(0, 1, 5'd3,  32'hFFFFFFFF, 4'hF,  0, 5'd0,  {5'd5, 5'd0, 5'd3, 5'd3},   {Z, Z, Z, Z},                 4'b0000, {Z, Z},      2'b00));
    tbl.push_back(mk(1, 0, 5'd0,  Z,            4'h0,  0, 5'd0,  {5'd3, 5'd3, 5'd3, 5'd3},   {Z, Z, Z, Z},                 4'b0000, {Z, Z},      2'b00));
    tbl.push_back(mk(1, 1, 5'd5,  P5,           4'hF,  0, 5'd0,  {5'd2, 5'd1, 5'd0, 5'd5},   {Z, Z, Z, P5},                4'b0000, {Z, Z},      2'b00));
    tbl.push_back(mk(1, 1, 5'd5,  32'hAABBCCDD, 4'h5,  0, 5'd0,  {5'd0, 5'd0, 5'd5, 5'd5},   {Z, Z, M5, M5},               4'b0000, {P5, P5},    2'b00));
    tbl.push_back(mk(1, 0, 5'd0,  Z,            4'h0,  0, 5'd0,  {5'd5, 5'd5, 5'd5, 5'd5},   {M5, M5, M5, M5},             4'b0000, {M5, M5},    2'b00));
    tbl.push_back(mk(1, 1, 5'd7,  DB,           4'hF,  0, 5'd0,  {5'd0, 5'd5, 5'd7, 5'd7},   {Z, M5, DB, DB},              4'b0000, {Z, Z},      2'b00));
    tbl.push_back(mk(1, 0, 5'd0,  Z,            4'h0,  0, 5'd0,  {5'd7, 5'd7, 5'd7, 5'd7},   {DB, DB, DB, DB},             4'b0000, {DB, DB},    2'b00));
    tbl.push_back(mk(1, 1, 5'd0,  32'h12345678, 4'hF,  1, 5'd0,  {5'd0, 5'd0, 5'd0, 5'd0},   {Z, Z, Z, Z},                 4'b0000, {Z, Z},      2'b00));
    tbl.push_back(mk(1, 0, 5'd0,  Z,            4'h0,  0, 5'd0,  {5'd0, 5'd0, 5'd0, 5'd0},   {Z, Z, Z, Z},                 4'b0000, {Z, Z},      2'b00));
    tbl.push_back(mk(1, 0, 5'd0,  Z,            4'h0,  1, 5'd9,  {5'd9, 5'd9, 5'd9, 5'd9},   {Z, Z, Z, Z},                 4'b0000, {Z, Z},      2'b00));
    tbl.push_back(mk(1, 0, 5'd0,  Z,            4'h0,  0, 5'd0,  {5'd7, 5'd0, 5'd9, 5'd9},   {DB, Z, Z, Z},                4'b0011, {Z, Z},      2'b11));
    tbl.push_back(mk(1, 1, 5'd9,  32'h99,       4'hF,  0, 5'd0,  {5'd9, 5'd7, 5'd9, 5'd9},   {32'h99, DB, 32'h99, 32'h99}, 4'b0000, {Z, Z},      2'b11));
    tbl.push_back(mk(1, 0, 5'd0,  Z,            4'h0,  0, 5'd0,  {5'd9, 5'd9, 5'd9, 5'd9},   {4{32'h99}},                  4'b0000, {2{32'h99}}, 2'b00));
    tbl.push_back(mk(1, 1, 5'd9,  32'h100,      4'hF,  1, 5'd9,  {5'd9, 5'd9, 5'd9, 5'd9},   {4{32'h100}},                 4'b0000, {2{32'h99}}, 2'b00));
    tbl.push_back(mk(1, 0, 5'd0,  Z,            4'h0,  0, 5'd0,  {5'd9, 5'd9, 5'd9, 5'd9},   {4{32'h100}},                 4'b1111, {2{32'h100}},2'b11));
    tbl.push_back(mk(1, 1, 5'd9,  32'h200,      4'h0,  1, 5'd10, {5'd10, 5'd9, 5'd10, 5'd9}, {Z, 32'h100, Z, 32'h100},     4'b0000, {Z, 32'h100}, 2'b01));
    tbl.push_back(mk(1, 0, 5'd0,  Z,            4'h0,  0, 5'd0,  {5'd10, 5'd9, 5'd10, 5'd9}, {Z, 32'h100, Z, 32'h100},     4'b1010, {Z, 32'h100}, 2'b10));
    tbl.push_back(mk(1, 1, 5'd1,  A1,           4'hF,  0, 5'd0,  {5'd31, 5'd3, 5'd2, 5'd1},  {Z, Z, Z, A1},                4'b0000, {Z, Z},      2'b00));
    tbl.push_back(mk(1, 1, 5'd2,  B2,           4'hF,  0, 5'd0,  {5'd31, 5'd3, 5'd2, 5'd1},  {Z, Z, B2, A1},               4'b0000, {Z, A1},     2'b00));
    tbl.push_back(mk(1, 1, 5'd3,  C3,           4'hF,  0, 5'd0,  {5'd31, 5'd3, 5'd2, 5'd1},  {Z, C3, B2, A1},              4'b0000, {B2, A1},    2'b00));
    tbl.push_back(mk(1, 1, 5'd31, F1,           4'hF,  0, 5'd0,  {5'd31, 5'd3, 5'd2, 5'd1},  {F1, C3, B2, A1},             4'b0000, {B2, A1},    2'b00));
    tbl.push_back(mk(1, 0, 5'd0,  Z,            4'h0,  1, 5'd31, {5'd31, 5'd3, 5'd2, 5'd1},  {F1, C3, B2, A1},             4'b0000, {B2, A1},    2'b00));
    tbl.push_back(mk(1, 0, 5'd0,  Z,            4'h0,  0, 5'd0,  {5'd31, 5'd31, 5'd31, 5'd31}, {F1, F1, F1, F1},           4'b1111, {F1, F1},    2'b11));
    tbl.push_back(mk(0, 1, 5'd31, Z,            4'hF,  1, 5'd2,  {5'd10, 5'd9, 5'd31, 5'd31}, {Z, 32'h100, F1, F1},        4'b1011, {F1, F1},    2'b11));
    tbl.push_back(mk(1, 0, 5'd0,  Z,            4'h0,  0, 5'd0,  {5'd10, 5'd9, 5'd31, 5'd31}, {Z, Z, Z, Z},                4'b0000, {Z, Z},      2'b00));
    tbl.push_back(mk(1, 0, 5'd0,  Z,            4'h0,  0, 5'd0,  {5'd5, 5'd3, 5'd2, 5'd1},   {Z, Z, Z, Z},                 4'b0000, {Z, Z},      2'b00));

    rst_n          = 1'b0;
    bus_a.wr_en    = 1'b0;
    bus_a.wr_addr  = '0;
    bus_a.wr_data  = '0;
    bus_a.wr_be    = '0;
    bus_a.iss_en   = 1'b0;
    bus_a.iss_addr = '0;
    bus_a.rd_addr  = '0;
    repeat (2) @(posedge clk);

    for (int n = 0; n < tbl.size(); n++) begin
      run_vec(tbl[n], $sformatf("v%0d", n));
    end

    // Assemble r12 one byte per cycle: bypass instance sees each new byte early, the other one cycle later.
    prev = '0;
    for (int k = 0; k < 4; k++) begin
      byt = 8'h10 + 8'(k);
      cur = prev;
      cur[8*k +: 8] = byt;
      run_vec(mk(1, 1, 5'd12, {4{byt}}, 4'(1 << k), 0, 5'd0, {5'd0, 5'd12, 5'd12, 5'd12},
                 {Z, cur, cur, cur}, 4'b0000, {prev, prev}, 2'b00), $sformatf("byte%0d", k));
      prev = cur;
    end
    run_vec(mk(1, 0, 5'd0, Z, 4'h0, 0, 5'd0, {5'd12, 5'd12, 5'd12, 5'd12},
               {4{32'h13121110}}, 4'b0000, {2{32'h13121110}}, 2'b00), "byte_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
